// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, default widths and rotated-priority pick for the round-robin arbiter.
package rr_arb_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int MAX_N_REQ = 16;
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;
  function automatic logic [MAX_N_REQ-1:0] rotate_pick(input logic [MAX_N_REQ-1:0] req, input int start, input int n);
    logic [MAX_N_REQ-1:0] w;
    int j;
    w = '0;
    for (int k = 0; k < MAX_N_REQ; k++) begin
      if (k < n) begin
        j = start + k;
        if (j >= n) j -= n;
        if (w == '0 && req[j[3:0]]) w[j[3:0]] = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/round_robin_arbiter_n_req_pick.sv
// rr_arb_pick: combinational picker, first set request at or after start with wrap-around.
module rr_arb_pick import rr_arb_pkg::*; #(
  parameter int N = DEF_N_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  assign winner = N'(rotate_pick(MAX_N_REQ'(req), int'(start), N));
  assign found = |winner;
  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) idx = winner[k] ? IDX_W'(k) : idx;
  end
endmodule

// File: rtl/round_robin_arbiter_n_req.sv
// round_robin_arbiter_n_req: N-way round-robin arbiter with grant locking and hold timeout.
// Optional RR_ARB_GRANT_STATS_EN adds per-requester 8-bit saturating grant-event counters.
module round_robin_arbiter_n_req import rr_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   requests,
  output logic [N_REQ-1:0]   grants,
  output logic               grant_valid,
`ifdef RR_ARB_GRANT_STATS_EN
  output logic [N_REQ*8-1:0] grant_counts,
`endif
  output logic [IDX_W-1:0]   grant_idx
);
  localparam int CNT_W = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_HOLD - 1);
  arb_state_t state;
  logic [IDX_W-1:0] ptr, start, win_idx;
  logic [N_REQ-1:0] win;
  logic [CNT_W-1:0] hold_cnt;
  logic found, keep, at_top;
  // ptr always holds the last winner, so searching from ptr+1 gives it lowest priority
  assign start = (ptr == IDX_W'(N_REQ - 1)) ? '0 : ptr + 1'b1;
  rr_arb_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(requests & ~grants),
    .start(start),
    .winner(win),
    .idx(win_idx),
    .found(found)
  );
  assign at_top = hold_cnt == CNT_TOP;
  assign keep = state == ARB_HOLD && requests[grant_idx] && !(at_top && found);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grants <= '0;
      grant_valid <= 1'b0;
      grant_idx <= '0;
      ptr <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= at_top ? hold_cnt : hold_cnt + 1'b1;
    end else if (found) begin
      state <= ARB_HOLD;
      grants <= win;
      grant_valid <= 1'b1;
      grant_idx <= win_idx;
      ptr <= win_idx;
      hold_cnt <= '0;
    end else begin
      state <= ARB_IDLE;
      grants <= '0;
      grant_valid <= 1'b0;
      grant_idx <= '0;
      hold_cnt <= '0;
    end
  end
`ifdef RR_ARB_GRANT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_counts <= '0;
    else if (!keep && found)
      for (int i = 0; i < N_REQ; i++)
        if (win[i] && grant_counts[i*8+:8] != 8'hff) grant_counts[i*8+:8] <= grant_counts[i*8+:8] + 8'd1;
  end
`endif
endmodule

// File: tb/tb_round_robin_arbiter_n_req.sv
// tb_round_robin_arbiter_n_req: vector tables, corner sequences and random traffic against a reference model.
module tb_round_robin_arbiter_n_req;
  logic clk = 1'b0, rst;
  logic [3:0] req_a, grants_a;
  logic [2:0] req_b, grants_b;
  logic [1:0] idx_a, idx_b;
  logic valid_a, valid_b;
`ifdef RR_ARB_GRANT_STATS_EN
  logic [31:0] counts_a;
  logic [23:0] counts_b;
`endif
  always #5 clk = ~clk;

  round_robin_arbiter_n_req #(.N_REQ(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .requests(req_a), .grants(grants_a), .grant_valid(valid_a),
`ifdef RR_ARB_GRANT_STATS_EN
    .grant_counts(counts_a),
`endif
    .grant_idx(idx_a));
  round_robin_arbiter_n_req #(.N_REQ(3), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .requests(req_b), .grants(grants_b), .grant_valid(valid_b),
`ifdef RR_ARB_GRANT_STATS_EN
    .grant_counts(counts_b),
`endif
    .grant_idx(idx_b));

  typedef struct { int holder; int ptr; int hcnt; int gc[16]; } mst_t;
  typedef struct { logic [3:0] ra; logic [3:0] exp_a; logic [2:0] rb; logic [2:0] exp_b; } vec_t;
  mst_t ma, mb;
  vec_t tbl[$];
  int n_checks = 0, n_fail = 0;

  function automatic mst_t model_reset(int n);
    mst_t s;
    s.holder = -1;
    s.ptr = n - 1;
    s.hcnt = 0;
    foreach (s.gc[k]) s.gc[k] = 0;
    return s;
  endfunction

  // holder=-1 means idle; search always begins just after the last winner
  function automatic mst_t model_next(mst_t s, logic [15:0] req, int n, int m);
    bit others = 0;
    int base, j;
    for (int k = 0; k < n; k++) if (k != s.holder && req[k]) others = 1;
    if (s.holder >= 0 && req[s.holder] && !(s.hcnt == m - 1 && others)) begin
      if (s.hcnt < m - 1) s.hcnt++;
      return s;
    end
    base = s.holder >= 0 ? s.holder : s.ptr;
    for (int k = 1; k <= n; k++) begin
      j = (base + k) % n;
      if (req[j] && j != s.holder) begin
        s.holder = j;
        s.ptr = j;
        s.hcnt = 0;
        if (s.gc[j] < 255) s.gc[j]++;
        return s;
      end
    end
    s.holder = -1;
    s.hcnt = 0;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_grants", int'(grants_a), ma.holder >= 0 ? (1 << ma.holder) : 0);
    check("a_valid", int'(valid_a), ma.holder >= 0 ? 1 : 0);
    check("a_idx", int'(idx_a), ma.holder >= 0 ? ma.holder : 0);
    check("a_onehot0", int'($onehot0(grants_a)), 1);
    check("b_grants", int'(grants_b), mb.holder >= 0 ? (1 << mb.holder) : 0);
    check("b_valid", int'(valid_b), mb.holder >= 0 ? 1 : 0);
    check("b_idx", int'(idx_b), mb.holder >= 0 ? mb.holder : 0);
    check("b_onehot0", int'($onehot0(grants_b)), 1);
`ifdef RR_ARB_GRANT_STATS_EN
    for (int k = 0; k < 4; k++) check("a_count", int'(counts_a[k*8+:8]), ma.gc[k]);
    for (int k = 0; k < 3; k++) check("b_count", int'(counts_b[k*8+:8]), mb.gc[k]);
`endif
  endtask

  task automatic step(input logic [3:0] ra, input logic [2:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    ma = model_next(ma, 16'(ra), 4, 4);
    mb = model_next(mb, 16'(rb), 3, 1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_a = '0;
    req_b = '0;
    rst = 1'b1;
    ma = model_reset(4);
    mb = model_reset(3);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 17; i++) tbl.push_back('{4'b1111, 4'(1 << ((i / 4) % 4)), 3'b111, 3'(1 << (i % 3))});
    for (int i = 17; i < 37; i++) tbl.push_back('{4'b0100, 4'b0100, 3'b111, 3'(1 << (i % 3))});
    tbl.push_back('{4'b0000, 4'b0000, 3'b111, 3'(1 << (37 % 3))});
    rst = 1'b1;
    req_a = '0;
    req_b = '0;
    ma = model_reset(4);
    mb = model_reset(3);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].ra, tbl[i].rb);
      check("tbl_a", int'(grants_a), int'(tbl[i].exp_a));
      check("tbl_b", int'(grants_b), int'(tbl[i].exp_b));
    end
    // zero-gap handover, then rotation continues from the new winner
    do_reset();
    step(4'b0001, 3'b000);
    check("ho_first", int'(grants_a), 1);
    step(4'b0100, 3'b000);
    check("ho_gapless", int'(grants_a), 4);
    step(4'b1011, 3'b000);
    check("ho_after2", int'(grants_a), 8);
    repeat (3) begin
      step(4'b1011, 3'b000);
      check("ho_hold3", int'(grants_a), 8);
    end
    step(4'b1011, 3'b000);
    check("ho_wrap0", int'(grants_a), 1);
    // asynchronous reset lands between clock edges
    do_reset();
    step(4'b0010, 3'b010);
    check("ar_pre", int'(grants_a), 2);
    #3;
    rst = 1'b1;
    ma = model_reset(4);
    mb = model_reset(3);
    #1;
    check("ar_grants", int'(grants_a), 0);
    check("ar_valid", int'(valid_a), 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 3'b000);
    check("ar_restart", int'(grants_a), 1);
    do_reset();
    repeat (400) step(4'($urandom), 3'($urandom));
`ifdef RR_ARB_GRANT_STATS_EN
    do_reset();
    repeat (300) begin
      step(4'b0010, 3'b001);
      step(4'b0000, 3'b000);
    end
    check("stats_sat", int'(counts_a[15:8]), 255);
    check("stats_lane0", int'(counts_a[7:0]), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
